// File: rtl/i2c_init_sequencer_if.sv
// Purpose : handshake bundle between the init sequencer and the
//           single-register I2C writer.
// Signals : cfg_start - one-cycle start pulse (sequencer -> writer)
//           cfg_id    - 8-bit device write address
//           cfg_reg   - register address of the current entry
//           cfg_data  - data byte of the current entry
//           cfg_done  - one-cycle completion pulse (writer -> sequencer)
// Modports: master = sequencer side, slave = writer side.
interface i2c_init_sequencer_if;
    logic       cfg_start;
    logic [7:0] cfg_id;
    logic [7:0] cfg_reg;
    logic [7:0] cfg_data;
    logic       cfg_done;

    modport master (
        output cfg_start,
        output cfg_id,
        output cfg_reg,
        output cfg_data,
        input  cfg_done
    );

    modport slave (
        input  cfg_start,
        input  cfg_id,
        input  cfg_reg,
        input  cfg_data,
        output cfg_done
    );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Purpose : walks a fixed init table after a power-up settle delay and
//           issues one register write at a time to the I2C register
//           writer. Entries with reg == 8'hFF are pure delays of
//           data*DELAY_UNIT clocks. Each write is guarded by a timeout.
//           A go pulse re-runs the table (no power-up wait) once the
//           previous run has finished or failed.
// Ports   : clk       - system clock, rising edge
//           reset     - asynchronous, active-low reset
//           go        - one-cycle restart pulse, honoured in DONE/FAIL only
//           cfg       - writer handshake (master modport)
//           busy      - sequence running
//           init_done - all entries written
//           error     - sticky timeout flag
//           entry_idx - entry in progress, or the failing entry
module i2c_init_sequencer #(
    parameter logic [7:0]  DEVICE_ID      = 8'hEC,
    parameter int unsigned NUM_ENTRIES    = 4,
    parameter int unsigned POWERUP_CYCLES = 1000000,
    parameter int unsigned DELAY_UNIT     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    i2c_init_sequencer_if.master        cfg,
    output logic                        busy,
    output logic                        init_done,
    output logic                        error,
    output logic [3:0]                  entry_idx
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  eidx_q, eidx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] rom_entry;
    logic [31:0] delay_len;

    // Init table: {reg, data}; reg == 8'hFF is a delay of data*DELAY_UNIT.
    function automatic logic [15:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = {8'hA1, 8'h09};
            4'd1:    rom = {8'hFF, 8'h02};
            4'd2:    rom = {8'hC8, 8'h00};
            4'd3:    rom = {8'hA1, 8'h09};
            default: rom = {8'hFF, 8'h00};
        endcase
    endfunction

    assign rom_entry = rom(idx_q);
    assign delay_len = {24'd0, data_q} * DELAY_UNIT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        reg_d   = reg_q;
        data_d  = data_q;
        eidx_d  = eidx_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q >= POWERUP_CYCLES - 1) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                reg_d   = rom_entry[15:8];
                data_d  = rom_entry[7:0];
                eidx_d  = idx_q;
                state_d = (rom_entry[15:8] == 8'hFF) ? S_DELAY : S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (cfg.cfg_done)
                    state_d = S_NEXT;
                else if (cnt_q >= TIMEOUT_CYCLES - 1)
                    state_d = S_FAIL;
            end
            S_DELAY: begin
                // A zero-length delay still spends one cycle here.
                if ((cnt_q + 32'd1) >= delay_len)
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == 4'(NUM_ENTRIES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE, S_FAIL: begin
                cnt_d = cnt_q;
                if (go) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // Counter restarts on every state entry; WAIT keeps counting from
        // ISSUE so the start cycle itself is part of the timeout window.
        if (state_d != state_q && state_d != S_WAIT)
            cnt_d = '0;

        busy_d = !(state_d == S_DONE || state_d == S_FAIL);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            eidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            eidx_q  <= eidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg.cfg_start = (state_q == S_ISSUE);
    assign cfg.cfg_id    = DEVICE_ID;
    assign cfg.cfg_reg   = reg_q;
    assign cfg.cfg_data  = data_q;
    assign busy          = busy_q;
    assign init_done     = done_q;
    assign error         = err_q;
    assign entry_idx     = eidx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Purpose : self-checking bench for i2c_init_sequencer. A timeline model
//           derives, per clock edge, the expected outputs from the table
//           contents and the writer latencies; a compare thread checks
//           every cycle against it. A few literal checks pin the model.
module tb_i2c_init_sequencer;
    localparam int PWR = 8;
    localparam int DU  = 4;
    localparam int TO  = 64;
    localparam int NE  = 4;
    localparam int NC  = 2048;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       go    = 1'b0;
    logic       busy, init_done, error;
    logic [3:0] entry_idx;

    i2c_init_sequencer_if bus();

    i2c_init_sequencer #(
        .DEVICE_ID      (8'hEC),
        .NUM_ENTRIES    (NE),
        .POWERUP_CYCLES (PWR),
        .DELAY_UNIT     (DU),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .cfg       (bus.master),
        .busy      (busy),
        .init_done (init_done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected trace {start, busy, init_done, error, idx, reg, data} per edge.
    logic [23:0] exp_v [NC];
    int          m_cur;
    logic        m_start, m_busy, m_idone, m_err;
    logic [3:0]  m_idx;
    logic [7:0]  m_reg, m_data;
    int          m_s [4];
    int          m_end;

    // Writer model state.
    int wlat [4];
    int wk;
    int n_starts = 0;
    int pend = 0;
    int due = 0;
    int inj_e = -100;

    function automatic logic [15:0] mrom(input int i);
        case (i)
            0:       mrom = 16'hA109;
            1:       mrom = 16'hFF02;
            2:       mrom = 16'hC800;
            3:       mrom = 16'hA109;
            default: mrom = 16'hFF00;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Fill expectations up to (not including) edge t with current values.
    task automatic at(input int t);
        for (int c = m_cur; c < t; c++)
            if (c < NC) exp_v[c] = {m_start, m_busy, m_idone, m_err, m_idx, m_reg, m_data};
        if (t > m_cur) m_cur = t;
    endtask

    // Plan a run. pwr=1: ref_e is the last edge held in reset.
    // pwr=0: ref_e is the edge at which go is sampled.
    task automatic run_model(input int ref_e, input bit pwr);
        int L, T, P, k, lat;
        logic [15:0] e;
        if (pwr) begin
            at(ref_e);
            m_start = 0; m_busy = 0; m_idone = 0; m_err = 0;
            m_idx = 0; m_reg = 0; m_data = 0;
            at(ref_e + 1);
            m_busy = 1;
            L = ref_e + PWR;
        end else begin
            at(ref_e);
            m_busy = 1; m_idone = 0; m_err = 0;
            L = ref_e;
        end
        k = 0;
        for (int i = 0; i < NE; i++) begin
            e = mrom(i);
            at(L + 1);
            m_idx = 4'(i); m_reg = e[15:8]; m_data = e[7:0];
            if (e[15:8] == 8'hFF) begin
                P = int'(e[7:0]) * DU;
                T = L + 2 + ((P == 0) ? 1 : P);
            end else begin
                m_start = 1; m_s[k] = L + 1;
                at(L + 2);
                m_start = 0;
                lat = wlat[k];
                k++;
                if (lat < 2 || lat > TO) begin
                    at(L + 1 + TO);
                    m_busy = 0; m_err = 1; m_end = L + 1 + TO;
                    return;
                end
                T = L + 2 + lat;
            end
            if (i == NE - 1) begin
                at(T);
                m_busy = 0; m_idone = 1; m_end = T;
            end else begin
                L = T;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge clk);
            #2;
            if (cyc < m_cur && cyc < NC) begin
                check("trace", 32'({bus.cfg_start, busy, init_done, error, entry_idx,
                                   bus.cfg_reg, bus.cfg_data}), 32'(exp_v[cyc]));
                check("cfg_id", 32'(bus.cfg_id), 32'h000000EC);
            end
        end
    endtask

    task automatic writer();
        int   lat;
        logic dn;
        forever begin
            @(negedge clk);
            dn = 1'b0;
            if (pend != 0 && cyc == due - 1) begin dn = 1'b1; pend = 0; end
            if (cyc == inj_e - 1) dn = 1'b1;
            bus.cfg_done = dn;
            if (bus.cfg_start === 1'b1) begin
                n_starts++;
                lat = (wk < 4) ? wlat[wk] : -1;
                wk++;
                if (lat > 0) begin pend = 1; due = cyc + lat; end
            end
        end
    endtask

    task automatic to_neg(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic go_at(input int g);
        to_neg(g - 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    int s0, g, er, l1;

    initial begin
        bus.cfg_done = 1'b0;
        m_cur = 1;
        m_start = 0; m_busy = 0; m_idone = 0; m_err = 0;
        m_idx = 0; m_reg = 0; m_data = 0;
        fork
            compare_loop();
            writer();
            begin
                #100000;
                $display("FAIL watchdog cyc=%0d required=<%0d", cyc, NC);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Power-on run, writer answers 10 clocks after each start.
        wlat = '{10, 10, 10, -1}; wk = 0; s0 = n_starts;
        run_model(3, 1'b1);
        at(m_end + 4);
        to_neg(3);
        reset = 1'b1;
        to_neg(12);
        check("s1_first_start", 32'(bus.cfg_start), 32'd1);
        check("s1_first_reg",   32'(bus.cfg_reg),   32'hA1);
        check("s1_first_data",  32'(bus.cfg_data),  32'h09);
        to_neg(34);
        check("s1_entry2_start", 32'(bus.cfg_start), 32'd1);
        check("s1_entry2_reg",   32'(bus.cfg_reg),   32'hC8);
        to_neg(56);
        check("s1_not_done_yet", 32'(init_done), 32'd0);
        to_neg(57);
        check("s1_init_done", 32'(init_done), 32'd1);
        check("s1_busy",      32'(busy),      32'd0);
        to_neg(m_end + 3);
        check("s1_start_count", 32'(n_starts - s0), 32'd3);

        // Writer never completes entry 2 -> timeout.
        wlat = '{10, -1, -1, -1}; wk = 0; s0 = n_starts;
        g = cyc + 2;
        run_model(g, 1'b0);
        at(m_end + 4);
        go_at(g);
        to_neg(m_s[1] + 63);
        check("s2_err_before", 32'(error), 32'd0);
        to_neg(m_s[1] + 64);
        check("s2_err",   32'(error),     32'd1);
        check("s2_idx",   32'(entry_idx), 32'd2);
        check("s2_busy",  32'(busy),      32'd0);
        check("s2_idone", 32'(init_done), 32'd0);
        to_neg(m_end + 3);
        check("s2_start_count", 32'(n_starts - s0), 32'd2);

        // Recovery from FAIL with go.
        wlat = '{10, 10, 10, -1}; wk = 0; s0 = n_starts;
        g = cyc + 2;
        run_model(g, 1'b0);
        at(m_end + 4);
        go_at(g);
        check("s3_err_clear", 32'(error), 32'd0);
        check("s3_busy",      32'(busy),  32'd1);
        to_neg(g + 1);
        check("s3_quick_start", 32'(bus.cfg_start), 32'd1);
        to_neg(m_end + 3);
        check("s3_idone", 32'(init_done), 32'd1);
        check("s3_start_count", 32'(n_starts - s0), 32'd3);

        // go while busy and a spurious done during the delay entry.
        wlat = '{6, 6, 6, -1}; wk = 0; s0 = n_starts;
        g = cyc + 2;
        run_model(g, 1'b0);
        at(m_end + 4);
        l1 = m_s[0] + 1 + 6;
        inj_e = l1 + 4;
        go_at(g);
        go_at(m_s[0] + 3);
        go_at(l1 + 5);
        to_neg(m_end + 3);
        check("s4_idone", 32'(init_done), 32'd1);
        check("s4_start_count", 32'(n_starts - s0), 32'd3);

        // Reset during WAIT of entry 2; its done arrives 2 clocks later.
        wlat = '{10, 5, 10, -1}; wk = 0;
        g = cyc + 2;
        run_model(g, 1'b0);
        at(m_end + 4);
        go_at(g);
        to_neg(m_s[1] + 2);
        reset = 1'b0;
        wk = 0; wlat = '{10, 10, 10, -1}; s0 = n_starts;
        #1;
        check("s5_rst_busy",  32'(busy),          32'd0);
        check("s5_rst_start", 32'(bus.cfg_start), 32'd0);
        check("s5_rst_idx",   32'(entry_idx),     32'd0);
        check("s5_rst_reg",   32'(bus.cfg_reg),   32'd0);
        check("s5_rst_data",  32'(bus.cfg_data),  32'd0);
        er = m_s[1] + 3;
        m_cur = er;
        run_model(er, 1'b1);
        at(m_end + 4);
        @(negedge clk);
        reset = 1'b1;
        to_neg(m_end + 3);
        check("s5_idone", 32'(init_done), 32'd1);
        check("s5_start_count", 32'(n_starts - s0), 32'd3);

        // Done coincident with the timeout cycle counts as success.
        wlat = '{64, 10, 64, -1}; wk = 0; s0 = n_starts;
        g = cyc + 2;
        run_model(g, 1'b0);
        at(m_end + 4);
        go_at(g);
        to_neg(m_s[0] + 65);
        check("s6_no_err", 32'(error), 32'd0);
        check("s6_busy",   32'(busy),  32'd1);
        to_neg(m_end + 3);
        check("s6_idone", 32'(init_done), 32'd1);
        check("s6_err_end", 32'(error), 32'd0);
        check("s6_start_count", 32'(n_starts - s0), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
